simd_mem_requester: RTL

//  Core-side initiator for the shared memory controller port. Takes one SIMD load/store

---
 rtl/gpu_mem_pkg.sv | 25 ++
 rtl/mem_phase_watchdog.sv | 27 ++
 rtl/simd_mem_requester.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/gpu_mem_pkg.sv
// Shared lane geometry, requester FSM states and lane slicing helpers for the GPU memory port.
package gpu_mem_pkg;

  localparam int unsigned N_CORES = 4;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  function automatic logic [DATA_W-1:0] lane_data(input logic [N_CORES*DATA_W-1:0] vec,
                                                  input int unsigned lane);
    return vec[lane*DATA_W +: DATA_W];
  endfunction

  function automatic logic [ADDR_W-1:0] lane_addr(input logic [N_CORES*ADDR_W-1:0] vec,
                                                  input int unsigned lane);
    return vec[lane*ADDR_W +: ADDR_W];
  endfunction

endpackage

// File: rtl/mem_phase_watchdog.sv
// Per-phase cycle counter for the memory requester; flags a phase that has lasted Limit cycles.
module mem_phase_watchdog #(
  parameter int unsigned Limit = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic active,
  output logic expired
);

  localparam int unsigned CntW = $clog2(Limit + 1);

  logic [CntW-1:0] cnt_q;

  // The current cycle is the Limit-th cycle of the phase when the count shows Limit-1.
  assign expired = active && (cnt_q == CntW'(Limit - 1));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (active && !expired) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/simd_mem_requester.sv
// SIMD load/store initiator towards the shared memory controller port.
// Define SIMD_MEM_TIMEOUT_EN to add a per-phase watchdog that ends a stalled access with an error.
module simd_mem_requester
  import gpu_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [N_CORES-1:0]        req_en,
  input  logic [N_CORES*ADDR_W-1:0] req_addr,
  input  logic [N_CORES*DATA_W-1:0] req_wdata,
  output logic                      resp_valid,
  output logic [N_CORES*DATA_W-1:0] resp_rdata,
  output logic                      resp_error,
  output logic                      MRead,
  output logic                      MWrite,
  input  logic                      MReady,
  output logic [N_CORES-1:0]        en,
  output logic [N_CORES*ADDR_W-1:0] addr,
  output logic [N_CORES*DATA_W-1:0] data,
  input  logic [N_CORES*DATA_W-1:0] q
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  state_e                    state_q, state_d;
  logic                      we_q;
  logic [N_CORES-1:0]        en_q;
  logic [N_CORES*ADDR_W-1:0] addr_q;
  logic [N_CORES*DATA_W-1:0] data_q;
  logic [N_CORES*DATA_W-1:0] rdata_q, rdata_d;
  logic                      error_q, error_d;
  logic                      resp_valid_q;
  logic                      accept;
  logic                      timeout;

  assign req_ready = (state_q == StIdle) && MReady && !reset;
  assign accept    = req_valid && req_ready;

`ifdef SIMD_MEM_TIMEOUT_EN
  logic phase_active, phase_clear;

  assign phase_active = state_q inside {StIssue, StWait};
  assign phase_clear  = (state_d != state_q) && (state_d inside {StIssue, StWait});

  mem_phase_watchdog #(
    .Limit(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (phase_clear),
    .active (phase_active),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    error_d = error_q;
    MRead   = 1'b0;
    MWrite  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_en == '0) begin
            // Empty mask: answer without touching the bus.
            state_d = StResp;
            rdata_d = '0;
            error_d = 1'b0;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        MRead  = ~we_q;
        MWrite = we_q;
        if (timeout) begin
          state_d = StResp;
          rdata_d = '0;
          error_d = 1'b1;
        end else if (!MReady) begin
          state_d = StWait;
        end
      end
      StWait: begin
        MRead  = ~we_q;
        MWrite = we_q;
        if (MReady) begin
          state_d = StResp;
          error_d = 1'b0;
          for (int unsigned i = 0; i < N_CORES; i++) begin
            rdata_d[i*DATA_W +: DATA_W] = (en_q[i] && !we_q) ? lane_data(q, i) : '0;
          end
        end else if (timeout) begin
          state_d = StResp;
          rdata_d = '0;
          error_d = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      en_q         <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      rdata_q      <= '0;
      error_q      <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rdata_q      <= rdata_d;
      error_q      <= error_d;
      // Response is presented the cycle after RESP so rdata/error are already settled.
      resp_valid_q <= (state_q == StResp);
      if (accept) begin
        we_q   <= req_we;
        en_q   <= req_en;
        addr_q <= req_addr;
        data_q <= req_wdata;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;
  assign en         = en_q;
  assign addr       = addr_q;
  assign data       = data_q;

endmodule
